// File: rtl/io_bus_bridge.sv
// CPU-to-peripheral IO bridge: decodes IO space, strobes one of NCH channels, returns data/error.
// Optional ACCESS timeout enabled by defining IO_BRIDGE_TIMEOUT_EN.
module io_bus_bridge #(
  parameter int unsigned NCH     = 4,
  parameter logic [7:0]  IO_BASE = 8'hC0,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic              is_io,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  output logic [3:0]        io_wstrb,
  output logic [NCH-1:0]    io_rd,
  output logic [NCH-1:0]    io_wr,
  input  logic [NCH*32-1:0] io_rdata,
  input  logic [NCH-1:0]    io_ready
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [4:0] NchW = 5'(NCH);

  state_e      state_q, state_d;
  logic [3:0]  ch_q, ch_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  logic           req;
  logic           bad_req;
  logic [31:0]    rdata_sel;
  logic           ready_sel;
  logic [NCH-1:0] ch_onehot;

  assign is_io   = (cpu_addr[31:24] == IO_BASE);
  assign req     = (cpu_rd | cpu_wr) & is_io;
  assign bad_req = ({1'b0, cpu_addr[23:20]} >= NchW) | (cpu_rd & cpu_wr);

  // Latched channel selects its data, ready and strobe bit; other channels are ignored.
  always_comb begin
    rdata_sel = '0;
    ready_sel = 1'b0;
    ch_onehot = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (ch_q == 4'(k)) begin
        rdata_sel    = io_rdata[32*k +: 32];
        ready_sel    = io_ready[k];
        ch_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`ifdef IO_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          ch_d    = cpu_addr[23:20];
          wr_d    = cpu_wr;
          addr_d  = {12'h0, cpu_addr[19:0]};
          wdata_d = cpu_wdata;
          wstrb_d = cpu_wstrb;
          if (bad_req) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = 32'hFFFF_FFFF;
          end else begin
            state_d = StAccess;
            err_d   = 1'b0;
`ifdef IO_BRIDGE_TIMEOUT_EN
            cnt_d   = 8'h0;
`endif
          end
        end
      end
      StAccess: begin
        // A ready in the final allowed cycle still completes without error.
        if (ready_sel) begin
          state_d = StResp;
          err_d   = 1'b0;
          rdata_d = wr_q ? 32'h0 : rdata_sel;
`ifdef IO_BRIDGE_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = 32'hFFFF_FFFF;
        end else begin
          cnt_d   = cnt_q + 8'h1;
`endif
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      ch_q    <= 4'h0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
`ifdef IO_BRIDGE_TIMEOUT_EN
      cnt_q   <= 8'h0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`ifdef IO_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign io_rd     = ((state_q == StAccess) && !wr_q) ? ch_onehot : '0;
  assign io_wr     = ((state_q == StAccess) &&  wr_q) ? ch_onehot : '0;
  assign cpu_ready = (state_q == StResp);
  assign cpu_err   = cpu_ready & err_q;
  assign cpu_rdata = rdata_q;
  assign io_addr   = addr_q;
  assign io_wdata  = wdata_q;
  assign io_wstrb  = wstrb_q;

endmodule

// File: doc/io_bus_bridge.md
IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

Interface
REQ-001 SHALL have parameter NCH, default 4, number of peripheral channels (1..16).
REQ-002 SHALL have parameter IO_BASE, default 8'hC0, value of cpu_addr[31:24] selecting IO space.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum ACCESS cycles before abort (1..255).
REQ-004 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port: resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: cpu_addr  in  32  CPU data address.
REQ-007 SHALL have port: cpu_wdata  in  32  CPU write data.
REQ-008 SHALL have port: cpu_wstrb  in  4  byte-lane write enables.
REQ-009 SHALL have port: cpu_rd  in  1  read request.
REQ-010 SHALL have port: cpu_wr  in  1  write request.
REQ-011 SHALL have port: is_io  out  1  combinational: cpu_addr[31:24]==IO_BASE.
REQ-012 SHALL have port: cpu_rdata  out  32  registered read data.
REQ-013 SHALL have port: cpu_ready  out  1  one-cycle completion pulse.
REQ-014 SHALL have port: cpu_err  out  1  error flag, valid with cpu_ready.
REQ-015 SHALL have port: io_addr  out  32  latched offset {12'h0, cpu_addr[19:0]}.
REQ-016 SHALL have port: io_wdata  out  32  latched write data.
REQ-017 SHALL have port: io_wstrb  out  4  latched byte enables.
REQ-018 SHALL have port: io_rd  out  NCH  one-hot read strobe.
REQ-019 SHALL have port: io_wr  out  NCH  one-hot write strobe.
REQ-020 SHALL have port: io_rdata  in  NCH*32  channel k read data at bits [32k+31:32k].
REQ-021 SHALL have port: io_ready  in  NCH  per-channel completion.

Function
REQ-022 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-023 In IDLE, request = (cpu_rd|cpu_wr) & is_io; non-IO requests SHALL be ignored.
REQ-024 On request, SHALL latch address offset, wdata, wstrb, direction and ch = cpu_addr[23:20].
REQ-025 If ch >= NCH, or cpu_rd & cpu_wr both high, SHALL go to RESP with error set, no io strobe.
REQ-026 Otherwise SHALL go to ACCESS; io_rd[ch] or io_wr[ch] high for every ACCESS cycle, all other strobe bits low.
REQ-027 In ACCESS, when io_ready[ch]=1, SHALL capture io_rdata[ch] (reads) into cpu_rdata, go to RESP, error clear.
REQ-028 io_ready bits of non-selected channels SHALL be ignored.
REQ-029 In RESP, cpu_ready=1 for exactly one cycle, then IDLE; next request acceptable in that IDLE cycle.
REQ-030 Minimum latency: request cycle N, strobe cycle N+1, cpu_ready cycle N+2 when io_ready immediate.
REQ-031 cpu_rd/cpu_wr/cpu_addr SHALL be ignored outside IDLE.
REQ-032 On any error, cpu_rdata SHALL be 32'hFFFF_FFFF; on write completion, cpu_rdata SHALL hold 32'h0.
REQ-033 cpu_rdata SHALL hold its value until next RESP.

Reset
REQ-034 resetn low SHALL asynchronously force IDLE, all outputs 0 (io_rd, io_wr, cpu_ready, cpu_err, cpu_rdata, io_addr, io_wdata, io_wstrb), timeout counter 0.
REQ-035 Reset mid-ACCESS SHALL drop strobes immediately; no cpu_ready SHALL be issued for the aborted transfer.

Configuration
REQ-036 Macro IO_BRIDGE_TIMEOUT_EN defined: 8-bit counter clears on entry to ACCESS, increments each ACCESS cycle; when it reaches TIMEOUT without io_ready, SHALL go to RESP with error, strobe dropped.
REQ-037 Macro undefined: no counter; ACCESS waits indefinitely; cpu_err only from REQ-025.
REQ-038 io_ready and timeout in the same cycle: io_ready SHALL win (no error).

Verification
REQ-039 Read ch2 addr 32'hC020_0010, io_ready[2]=1 first ACCESS cycle, io_rdata ch2=32'h1234_5678 -> io_addr=32'h10, cpu_ready cycle N+2, cpu_rdata=32'h1234_5678, cpu_err=0.
REQ-040 Write ch0 addr 32'hC000_0004 data 32'hA5A5_A5A5 wstrb 4'b0011, io_ready after 3 cycles -> io_wr=4'b0001 for 3 cycles, io_wdata/io_wstrb as latched, cpu_ready=1 err=0.
REQ-041 Read addr 32'hC050_0000 with NCH=4 -> no io strobe, cpu_ready cycle N+1, cpu_err=1, cpu_rdata=32'hFFFF_FFFF.
REQ-042 With IO_BRIDGE_TIMEOUT_EN, TIMEOUT=15, io_ready never set -> strobe 15 cycles, then cpu_ready=1, cpu_err=1; io_ready asserted on the 15th cycle -> cpu_err=0.
REQ-043 Request to 32'h0000_1000 -> is_io=0, FSM stays IDLE, no strobes; back-to-back IO reads accepted in IDLE after RESP.
REQ-044 resetn low during ACCESS -> io_rd=0 same cycle, no cpu_ready after release, next request served normally.
